harmonic_synth: RTL and testbench
=================================

Name: harmonic_synth

Overview:
Time-multiplexed additive synthesiser: a bank of N_HARM phasors (harmonics 1..N_HARM of one fundamental), each with its own signed sine and cosine magnitude.
- Each accepted sample_tick sweeps all harmonics through one shared sin/cos ROM and one multiply-accumulate pipeline.
- The result is one summed sample per tick.
- Sits between the sample-rate strobe generator and the audio/DAC output path.
- Supersedes the single-harmonic phasor: adds parametrised harmonic count, widths, double-buffered coefficients and a handshake.

Parameters:
N_HARM, 16, number of harmonics (index k produces harmonic k+1); >=2
PHASE_W, 8, phase accumulator width (one full cycle = 2^PHASE_W)
ROM_AW, 8, ROM address width; ROM_AW <= PHASE_W
ROM_DW, 16, ROM sample width, signed Q1.(ROM_DW-1), full scale +/-32767
COEF_W, 4, signed magnitude width
OUT_W, ROM_DW+COEF_W+1+$clog2(N_HARM), output width (default 25)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
sample_tick  in  1  request one output sample
freq_step  in  PHASE_W  fundamental phase increment per sample, unsigned
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(N_HARM)  harmonic index
coef_sin  in  COEF_W  signed sine magnitude
coef_cos  in  COEF_W  signed cosine magnitude
clr_overrun  in  1  clears overrun
busy  out  1  sweep in progress
out_valid  out  1  one-cycle pulse, out updated
out  out  OUT_W  signed summed sample, held between pulses
overrun  out  1  sticky: a tick was dropped

Behaviour:
- Reset (async assert) zeroes all state:
  - out=0, out_valid=0, busy=0, overrun=0.
  - base_phase=0.
  - Both coefficient banks = 0.
  - Pipeline is flushed.
- Reset mid-sweep aborts the sweep; no out_valid follows.
- Coefficients:
  - The write to pending[coef_addr] happens on the clk edge where coef_we=1.
  - coef_addr >= N_HARM: the write is ignored.
  - At an accepted tick, pending is copied to active. A write in the same cycle as the accepted tick is included in the copy.
  - Writes during a sweep never affect the current sweep.
- Tick acceptance: sample_tick=1 with busy=0 at edge T is accepted:
  - snap <= base_phase; base_phase <= base_phase + freq_step (mod 2^PHASE_W).
  - busy <= 1.
- Tick dropped: sample_tick=1 with busy=1 is dropped, and overrun <= 1.
- overrun clearing: clr_overrun=1 clears overrun. If clr_overrun and a dropped tick occur in the same cycle, overrun stays 1 (set wins).
- Sweep FSM states: IDLE -> ISSUE (N_HARM cycles) -> DRAIN (3 cycles) -> IDLE.
- ISSUE, cycle k:
  - Harmonic phase hp_k = snap*(k+1) mod 2^PHASE_W, generated incrementally (hp_0=snap, hp_{k+1}=hp_k+snap); no multiplier.
  - ROM address = hp_k[PHASE_W-1 -: ROM_AW].
- Pipeline stages:
  - s1: ROM registered output (1-cycle latency).
  - s2: p = sin*active_sin[k] + cos*active_cos[k], registered, ROM_DW+COEF_W+1 bits, sign-extended.
  - s3: acc += p; acc is cleared at the first harmonic.
- Output timing:
  - out <= acc_final and out_valid=1 for exactly one cycle, asserted at edge T+N_HARM+3.
  - busy falls at that same edge.
  - A tick sampled in the out_valid cycle is accepted: max rate is one sample per N_HARM+3 cycles.
- Arithmetic: full precision, no saturation. OUT_W guarantees no overflow for all coefficient and ROM values.
- Phase wrap: phase wraps modulo 2^PHASE_W; harmonic aliasing above Nyquist is accepted and not detected.
- freq_step=0: every sample is the value at snap=0, i.e. sum of cos magnitudes * 32767.

Decomposition:
- Package harmonic_synth_pkg:
  - Width functions for OUT_W and the product width.
  - Sweep FSM state enum (IDLE, ISSUE, DRAIN).
  - Constant ROM_FS = 32767.
- Sub-module sincos_rom:
  - Ports: clk, address[ROM_AW], sine/cosine[ROM_DW].
  - One-cycle registered read.
  - Quarter-phase-exact table: address 2^(ROM_AW-2) gives sine=32767, cosine=0.

Test Plan:
- Reset/idle: assert reset mid-sweep (cycle 5 of 19) -> out=0, out_valid never pulses, busy=0, overrun=0; first tick after release uses snap=0.
- Fundamental only: pending[0]=(sin 1, cos 0), freq_step=64, four ticks -> out = 0, 32767, 0, -32767.
- Harmonic 2 cosine: pending[1]=(sin 0, cos -3), all others 0, freq_step=64. The second tick has snap=64, hp=128, cosine=-32767 -> out=98301.
- Latency/overrun: tick at edge T -> out_valid only at edge T+19 (N_HARM=16). Then:
  - A tick at T+5 -> dropped, overrun=1.
  - A tick at T+19 -> accepted.
  - clr_overrun -> overrun=0.
- Double buffering: with pending[0]=(1,0), write pending[0]=(-1,0) during a sweep with snap=64 -> that sample is 32767; the next sample with snap=64 is -32767.
- Full-scale sum: N_HARM=16, all coef=(-8,-8), freq_step=0 -> out = 16*(-8*32767) = -4194176, no overflow.

Source files
------------

// File: rtl/harmonic_synth_pkg.sv
// rtl/harmonic_synth_pkg.sv - shared widths, sweep states and ROM scale for harmonic_synth
package harmonic_synth_pkg;

    localparam int ROM_FS = 32767;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    function automatic int prod_width(input int rom_dw, input int coef_w);
        return rom_dw + coef_w + 1;
    endfunction

    function automatic int out_width(input int rom_dw, input int coef_w, input int n_harm);
        return rom_dw + coef_w + 1 + $clog2(n_harm);
    endfunction

endpackage

// File: rtl/harmonic_synth_if.sv
// rtl/harmonic_synth_if.sv - tick, coefficient and sample handshake bundle for harmonic_synth
interface harmonic_synth_if
    import harmonic_synth_pkg::*;
#(
    parameter int N_HARM  = 16,
    parameter int PHASE_W = 8,
    parameter int ROM_DW  = 16,
    parameter int COEF_W  = 4,
    parameter int OUT_W   = out_width(ROM_DW, COEF_W, N_HARM)
) ();
    logic                       sample_tick;
    logic [PHASE_W-1:0]         freq_step;
    logic                       coef_we;
    logic [$clog2(N_HARM)-1:0]  coef_addr;
    logic signed [COEF_W-1:0]   coef_sin;
    logic signed [COEF_W-1:0]   coef_cos;
    logic                       clr_overrun;
    logic                       busy;
    logic                       out_valid;
    logic signed [OUT_W-1:0]    out;
    logic                       overrun;

    modport master (
        output sample_tick, freq_step, coef_we, coef_addr, coef_sin, coef_cos, clr_overrun,
        input  busy, out_valid, out, overrun
    );

    modport slave (
        input  sample_tick, freq_step, coef_we, coef_addr, coef_sin, coef_cos, clr_overrun,
        output busy, out_valid, out, overrun
    );
endinterface

// File: rtl/harmonic_synth_sincos_rom.sv
// rtl/harmonic_synth_sincos_rom.sv - registered sine/cosine lookup built from a quarter-wave table
module sincos_rom
    import harmonic_synth_pkg::*;
#(
    parameter int ROM_AW = 8,
    parameter int ROM_DW = 16
) (
    input  logic                     clk,
    input  logic [ROM_AW-1:0]        address,
    output logic signed [ROM_DW-1:0] sine,
    output logic signed [ROM_DW-1:0] cosine
);
    localparam int Q = 2 ** (ROM_AW - 2);

    // Taylor series in Q30 fixed point, rounded; endpoints land exactly on 0 and full scale.
    function automatic logic signed [ROM_DW-1:0] quarter_sin(input int i);
        longint s, half_pi, x, x2, term, sum, v;
        s       = 64'sd1 << 30;
        half_pi = 64'sd1686629713;
        x       = (half_pi * longint'(i)) / longint'(Q);
        x2      = (x * x) / s;
        term    = x;
        sum     = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) / s) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        v = (sum * longint'(ROM_FS) + s / 2) / s;
        if (v > longint'(ROM_FS)) v = longint'(ROM_FS);
        if (v < 0) v = 0;
        return ROM_DW'(v);
    endfunction

    logic signed [ROM_DW-1:0] tbl [0:Q];

    for (genvar i = 0; i <= Q; i++) begin : g_tbl
        localparam logic signed [ROM_DW-1:0] V = quarter_sin(i);
        assign tbl[i] = V;
    end

    function automatic logic signed [ROM_DW-1:0] wave(input logic [ROM_AW-1:0] a);
        logic [ROM_AW-3:0]        idx;
        logic [ROM_AW-2:0]        mir;
        logic signed [ROM_DW-1:0] mag;
        idx = a[ROM_AW-3:0];
        mir = (ROM_AW-1)'(Q) - {1'b0, idx};
        mag = a[ROM_AW-2] ? tbl[mir] : tbl[{1'b0, idx}];
        return a[ROM_AW-1] ? -mag : mag;
    endfunction

    always_ff @(posedge clk) begin
        sine   <= wave(address);
        cosine <= wave(address + ROM_AW'(Q));
    end
endmodule

// File: rtl/harmonic_synth.sv
// rtl/harmonic_synth.sv - time-multiplexed additive synthesiser, one summed sample per accepted tick
module harmonic_synth
    import harmonic_synth_pkg::*;
#(
    parameter int N_HARM  = 16,
    parameter int PHASE_W = 8,
    parameter int ROM_AW  = 8,
    parameter int ROM_DW  = 16,
    parameter int COEF_W  = 4,
    parameter int OUT_W   = out_width(ROM_DW, COEF_W, N_HARM)
) (
    input logic             clk,
    input logic             reset,
    harmonic_synth_if.slave bus
);
    localparam int AW = $clog2(N_HARM);
    localparam int CW = AW + 1;
    localparam int PW = prod_width(ROM_DW, COEF_W);

    state_t                   state, state_nx;
    logic [CW-1:0]            cnt, cnt_nx;
    logic                     finishing, accept, drop;
    logic [PHASE_W-1:0]       base_phase, snap, hp;
    logic signed [COEF_W-1:0] pend_sin [N_HARM];
    logic signed [COEF_W-1:0] pend_cos [N_HARM];
    logic signed [COEF_W-1:0] pend_sin_nx [N_HARM];
    logic signed [COEF_W-1:0] pend_cos_nx [N_HARM];
    logic signed [COEF_W-1:0] act_sin [N_HARM];
    logic signed [COEF_W-1:0] act_cos [N_HARM];
    logic signed [ROM_DW-1:0] rom_sin, rom_cos;
    logic                     v1, f1, l1, v2, f2, l2, v3;
    logic [AW-1:0]            k1;
    logic signed [PW-1:0]     prod;
    logic signed [OUT_W-1:0]  acc, out_q;
    logic                     out_valid_q, overrun_q;

    // The final drain cycle can take a new tick, so back-to-back sweeps overlap the pipeline tail.
    assign finishing = (state == DRAIN) && (cnt == CW'(2));
    assign accept    = bus.sample_tick && ((state == IDLE) || finishing);
    assign drop      = bus.sample_tick && !accept;

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.overrun   = overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = ISSUE;
                    cnt_nx   = '0;
                end
            end
            ISSUE: begin
                if (cnt == CW'(N_HARM - 1)) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_nx = ISSUE;
                    cnt_nx   = '0;
                end else if (finishing) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        pend_sin_nx = pend_sin;
        pend_cos_nx = pend_cos;
        if (bus.coef_we && ({1'b0, bus.coef_addr} < CW'(N_HARM))) begin
            pend_sin_nx[bus.coef_addr] = bus.coef_sin;
            pend_cos_nx[bus.coef_addr] = bus.coef_cos;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_HARM; i++) begin
                pend_sin[i] <= '0;
                pend_cos[i] <= '0;
                act_sin[i]  <= '0;
                act_cos[i]  <= '0;
            end
        end else begin
            pend_sin <= pend_sin_nx;
            pend_cos <= pend_cos_nx;
            if (accept) begin
                act_sin <= pend_sin_nx;
                act_cos <= pend_cos_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_phase <= '0;
            snap       <= '0;
            hp         <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (accept) begin
                snap       <= base_phase;
                base_phase <= base_phase + bus.freq_step;
                hp         <= base_phase;
            end else if (state == ISSUE) begin
                hp <= hp + snap;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    sincos_rom #(.ROM_AW(ROM_AW), .ROM_DW(ROM_DW)) u_rom (
        .clk     (clk),
        .address (hp[PHASE_W-1 -: ROM_AW]),
        .sine    (rom_sin),
        .cosine  (rom_cos)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {v1, f1, l1, v2, f2, l2, v3} <= '0;
            k1          <= '0;
            prod        <= '0;
            acc         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v1 <= (state == ISSUE);
            f1 <= (cnt == '0);
            l1 <= (cnt == CW'(N_HARM - 1));
            k1 <= cnt[AW-1:0];
            v2 <= v1;
            f2 <= f1;
            l2 <= l1;
            if (v1) begin
                prod <= PW'(rom_sin) * PW'(act_sin[k1]) + PW'(rom_cos) * PW'(act_cos[k1]);
            end
            if (v2) begin
                acc <= f2 ? OUT_W'(prod) : acc + OUT_W'(prod);
            end
            v3          <= v2 && l2;
            out_valid_q <= v3;
            if (v3) begin
                out_q <= acc;
            end
        end
    end
endmodule

// File: tb/tb_harmonic_synth.sv
// tb/tb_harmonic_synth.sv - randomized self-checking bench for harmonic_synth against a sum-of-sines model
module tb_harmonic_synth;
    import harmonic_synth_pkg::*;

    localparam int  N_HARM  = 16;
    localparam int  PHASE_W = 8;
    localparam int  ROM_AW  = 8;
    localparam int  ROM_DW  = 16;
    localparam int  COEF_W  = 4;
    localparam int  OUT_W   = 25;
    localparam real PI      = 3.14159265358979323846;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    harmonic_synth_if #(.N_HARM(N_HARM), .PHASE_W(PHASE_W), .ROM_DW(ROM_DW),
                        .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

    harmonic_synth #(.N_HARM(N_HARM), .PHASE_W(PHASE_W), .ROM_AW(ROM_AW), .ROM_DW(ROM_DW),
                     .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int chk_cnt = 0;
    int err_cnt = 0;
    int pend_s [N_HARM];
    int pend_c [N_HARM];
    int act_s  [N_HARM];
    int act_c  [N_HARM];
    int base   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rom_val(input int a, input bit want_cos);
        real ang, r;
        ang = 2.0 * PI * real'(a) / real'(2 ** ROM_AW);
        r   = 32767.0 * (want_cos ? $cos(ang) : $sin(ang));
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    task automatic model_reset();
        base = 0;
        for (int i = 0; i < N_HARM; i++) begin
            pend_s[i] = 0; pend_c[i] = 0; act_s[i] = 0; act_c[i] = 0;
        end
    endtask

    // Sum over harmonics of sin(hp)*s_k + cos(hp)*c_k with hp = snap*(k+1) mod 2^PHASE_W.
    task automatic model_accept(output longint e);
        int snap, hp, a;
        act_s = pend_s;
        act_c = pend_c;
        snap  = base;
        base  = (base + int'(bus.freq_step)) % (2 ** PHASE_W);
        e     = 0;
        for (int k = 0; k < N_HARM; k++) begin
            hp = (snap * (k + 1)) % (2 ** PHASE_W);
            a  = hp / (2 ** (PHASE_W - ROM_AW));
            e += longint'(rom_val(a, 1'b0) * act_s[k] + rom_val(a, 1'b1) * act_c[k]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        step(2);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wr_coef(input int addr, input int s, input int c);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(addr);
        bus.coef_sin  = COEF_W'(s);
        bus.coef_cos  = COEF_W'(c);
        step(1);
        bus.coef_we = 1'b0;
        if (addr < N_HARM) begin
            pend_s[addr] = s;
            pend_c[addr] = c;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            step(1);
            n++;
        end
        check("valid_seen", longint'(bus.out_valid), 1);
    endtask

    task automatic tick_and_wait(input string tag, output longint got);
        longint e;
        int     n;
        model_accept(e);
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        wait_valid(n);
        check({tag, "_lat"}, longint'(n), longint'(N_HARM + 3));
        got = bus.out;
        check(tag, got, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint got, e1, e2, e3;
        int     n, seen;
        int     fund_exp [4];

        bus.sample_tick = 1'b0; bus.freq_step = '0; bus.coef_we = 1'b0; bus.coef_addr = '0;
        bus.coef_sin = '0; bus.coef_cos = '0; bus.clr_overrun = 1'b0;
        model_reset();
        step(2);
        reset = 1'b0;

        check("rst_busy", longint'(bus.busy), 0);
        check("rst_out", longint'(bus.out), 0);
        check("rst_valid", longint'(bus.out_valid), 0);
        check("rst_overrun", longint'(bus.overrun), 0);

        // reset in the middle of a sweep
        bus.freq_step   = 8'd64;
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        step(4);
        check("mid_busy", longint'(bus.busy), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_out", longint'(bus.out), 0);
        check("abort_overrun", longint'(bus.overrun), 0);
        step(2);
        reset = 1'b0;
        model_reset();
        seen = 0;
        repeat (25) begin
            step(1);
            if (bus.out_valid) seen = 1;
        end
        check("abort_no_valid", longint'(seen), 0);
        wr_coef(0, 0, 1);
        tick_and_wait("post_reset", got);
        check("post_reset_snap0", got, 32767);

        // fundamental only
        do_reset();
        wr_coef(0, 1, 0);
        bus.freq_step = 8'd64;
        fund_exp = '{0, 32767, 0, -32767};
        for (int i = 0; i < 4; i++) begin
            tick_and_wait("fund", got);
            check("fund_const", got, longint'(fund_exp[i]));
        end

        // second harmonic cosine
        do_reset();
        wr_coef(1, 0, -3);
        tick_and_wait("h2_first", got);
        check("h2_first_const", got, -98301);
        tick_and_wait("h2_second", got);
        check("h2_second_const", got, 98301);

        // latency, dropped tick, back-to-back acceptance, overrun clearing
        do_reset();
        wr_coef(0, 1, 1);
        wr_coef(2, -2, 3);
        bus.freq_step = 8'd37;
        model_accept(e1);
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        step(4);
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        check("drop_overrun", longint'(bus.overrun), 1);
        check("drop_busy", longint'(bus.busy), 1);
        step(13);
        check("early_valid", longint'(bus.out_valid), 0);
        model_accept(e2);
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        check("lat_valid", longint'(bus.out_valid), 1);
        check("lat_out", longint'(bus.out), e1);
        check("b2b_busy", longint'(bus.busy), 1);
        step(18);
        check("b2b_early", longint'(bus.out_valid), 0);
        step(1);
        check("b2b_valid", longint'(bus.out_valid), 1);
        check("b2b_out", longint'(bus.out), e2);
        check("b2b_idle", longint'(bus.busy), 0);
        model_accept(e3);
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        step(1);
        bus.sample_tick = 1'b1;
        bus.clr_overrun = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        bus.clr_overrun = 1'b0;
        check("set_wins", longint'(bus.overrun), 1);
        bus.clr_overrun = 1'b1;
        step(1);
        bus.clr_overrun = 1'b0;
        check("clr_overrun", longint'(bus.overrun), 0);
        wait_valid(n);
        check("third_out", longint'(bus.out), e3);

        // double-buffered coefficients
        do_reset();
        wr_coef(0, 1, 0);
        bus.freq_step = 8'd64;
        tick_and_wait("db_first", got);
        model_accept(e1);
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        wr_coef(0, -1, 0);
        wait_valid(n);
        check("db_old", longint'(bus.out), 32767);
        check("db_old_model", longint'(bus.out), e1);
        bus.freq_step = 8'd192;
        tick_and_wait("db_mid", got);
        bus.freq_step = 8'd64;
        tick_and_wait("db_new", got);
        check("db_new_const", got, -32767);
        bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_sin = 4'sd0; bus.coef_cos = 4'sd2;
        pend_s[0] = 0; pend_c[0] = 2;
        model_accept(e1);
        bus.sample_tick = 1'b1;
        step(1);
        bus.sample_tick = 1'b0;
        bus.coef_we = 1'b0;
        wait_valid(n);
        check("same_cycle_wr", longint'(bus.out), -65534);
        check("same_cycle_model", longint'(bus.out), e1);

        // full-scale negative sum
        do_reset();
        bus.freq_step = 8'd0;
        for (int k = 0; k < N_HARM; k++) wr_coef(k, -8, -8);
        tick_and_wait("full_scale", got);
        check("full_scale_const", got, -4194176);

        // randomized coefficients, steps and mid-sweep writes
        for (int it = 0; it < 24; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                wr_coef($urandom_range(0, N_HARM - 1), $urandom_range(0, 15) - 8,
                        $urandom_range(0, 15) - 8);
            bus.freq_step = PHASE_W'($urandom);
            model_accept(e1);
            bus.sample_tick = 1'b1;
            step(1);
            bus.sample_tick = 1'b0;
            if ($urandom_range(0, 1) == 1)
                wr_coef($urandom_range(0, N_HARM - 1), $urandom_range(0, 15) - 8,
                        $urandom_range(0, 15) - 8);
            wait_valid(n);
            check("rand_out", longint'(bus.out), e1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end
endmodule
